// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, M-register control payload and condition evaluation
// used by the execute stage.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;
    localparam logic [3:0] ALU_MUL = 4'h4;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] RNONE = 4'hF;

    localparam int unsigned CC_ZF = 2;
    localparam int unsigned CC_SF = 1;
    localparam int unsigned CC_OF = 0;
    localparam logic [2:0]  CC_RESET = 3'b100;

    typedef struct packed {
        logic [1:0] stat;
        logic [3:0] icode;
        logic [3:0] ifun;
        logic       cnd;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } m_ctrl_t;

    localparam m_ctrl_t M_CTRL_BUBBLE = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        cnd:   1'b0,
        dst_e: RNONE,
        dst_m: RNONE
    };

    // Branch / conditional-move predicate from the {zf,sf,of} flags.
    function automatic logic cond_eval(input logic [2:0] cc, input logic [3:0] ifun);
        logic zf;
        logic lt;
        logic res;
        zf = cc[CC_ZF];
        lt = cc[CC_SF] ^ cc[CC_OF];
        case (ifun)
            C_YES:   res = 1'b1;
            C_LE:    res = lt | zf;
            C_L:     res = lt;
            C_E:     res = zf;
            C_NE:    res = ~zf;
            C_GE:    res = ~lt;
            C_G:     res = ~lt & ~zf;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/y86_execute_stage_mul.sv
// Sequential shift-add multiplier for mulq: IDLE -> RUN (XLEN steps) -> DONE.
// Only instantiated when Y86_EXEC_MUL_EN is defined.
module y86_mul_seq #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // busy covers the entry cycle and every RUN step unless the op was squashed.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy     = 1'b1;
                    mcand_d  = b;
                    mplier_d = a;
                    acc_d    = '0;
                    cnt_d    = CW'(XLEN - 1);
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    busy = 1'b1;
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign product = acc_q;

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, cond evaluation and E->M register.
// Optional mulq support is built when Y86_EXEC_MUL_EN is defined.
module y86_execute_stage
    import y86_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      E_stat,
    input  logic [3:0]      E_icode,
    input  logic [3:0]      E_ifun,
    input  logic [XLEN-1:0] E_valA,
    input  logic [XLEN-1:0] E_valB,
    input  logic [XLEN-1:0] E_valC,
    input  logic [3:0]      E_dstE,
    input  logic [3:0]      E_dstM,
    input  logic            set_cc,
    input  logic            M_stall,
    input  logic            M_bubble,
    output logic [1:0]      M_stat,
    output logic [3:0]      M_icode,
    output logic [3:0]      M_ifun,
    output logic            M_cnd,
    output logic [XLEN-1:0] M_valA,
    output logic [XLEN-1:0] M_valE,
    output logic [3:0]      M_dstE,
    output logic [3:0]      M_dstM,
    output logic [XLEN-1:0] e_valE,
    output logic [3:0]      e_dstE,
    output logic            e_cnd,
    output logic            e_busy,
    output logic [2:0]      cc_out
);

    localparam logic [XLEN-1:0] STACK_STEP = XLEN'(8);

    logic            is_opq;
    logic            op_valid;
    logic            res_valid;
    logic [XLEN-1:0] alu_res;
    logic            alu_of;
    logic [2:0]      flags;
    logic [2:0]      cc_q, cc_d;
    m_ctrl_t         m_ctrl_q, m_ctrl_d;
    logic [XLEN-1:0] m_val_a_q, m_val_a_d;
    logic [XLEN-1:0] m_val_e_q, m_val_e_d;

    assign is_opq = (E_icode == I_OPQ);

`ifdef Y86_EXEC_MUL_EN
    logic            is_mul;
    logic            mul_busy;
    logic            mul_done;
    logic [XLEN-1:0] mul_prod;

    assign is_mul    = is_opq && (E_ifun == ALU_MUL);
    assign op_valid  = (E_ifun <= ALU_MUL);
    assign res_valid = !is_mul || mul_done;
    assign e_busy    = mul_busy;

    y86_mul_seq #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (is_mul),
        .abort   (!is_mul),
        .a       (E_valA),
        .b       (E_valB),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign op_valid  = (E_ifun <= ALU_XOR);
    assign res_valid = 1'b1;
    assign e_busy    = 1'b0;
`endif

    // ALU result and signed-overflow detection; invalid ifun yields zero.
    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        case (E_icode)
            I_RRMOVQ:           alu_res = E_valA;
            I_IRMOVQ:           alu_res = E_valC;
            I_RMMOVQ, I_MRMOVQ: alu_res = E_valB + E_valC;
            I_OPQ: begin
                case (E_ifun)
                    ALU_ADD: begin
                        alu_res = E_valB + E_valA;
                        alu_of  = (E_valA[XLEN-1] == E_valB[XLEN-1]) &&
                                  (alu_res[XLEN-1] != E_valB[XLEN-1]);
                    end
                    ALU_SUB: begin
                        alu_res = E_valB - E_valA;
                        alu_of  = (E_valA[XLEN-1] != E_valB[XLEN-1]) &&
                                  (alu_res[XLEN-1] != E_valB[XLEN-1]);
                    end
                    ALU_AND: alu_res = E_valB & E_valA;
                    ALU_XOR: alu_res = E_valB ^ E_valA;
`ifdef Y86_EXEC_MUL_EN
                    ALU_MUL: alu_res = mul_prod;
`endif
                    default: alu_res = '0;
                endcase
            end
            I_CALL, I_PUSHQ:    alu_res = E_valB - STACK_STEP;
            I_RET, I_POPQ:      alu_res = E_valB + STACK_STEP;
            default:            alu_res = '0;
        endcase
    end

    assign flags  = {alu_res == '0, alu_res[XLEN-1], alu_of};
    assign e_valE = alu_res;
    assign e_cnd  = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) ? cond_eval(cc_q, E_ifun) : 1'b0;
    assign e_dstE = ((E_icode == I_RRMOVQ) && !e_cnd) ? RNONE : E_dstE;

    // CC update and M-register next state: stall > bubble/busy > load.
    always_comb begin
        cc_d      = cc_q;
        m_ctrl_d  = m_ctrl_q;
        m_val_a_d = m_val_a_q;
        m_val_e_d = m_val_e_q;
        if (is_opq && op_valid && set_cc && (E_stat == STAT_AOK) && res_valid) begin
            cc_d = flags;
        end
        if (M_stall) begin
            m_ctrl_d = m_ctrl_q;
        end else if (M_bubble || e_busy) begin
            m_ctrl_d  = M_CTRL_BUBBLE;
            m_val_a_d = '0;
            m_val_e_d = '0;
        end else begin
            m_ctrl_d.stat  = (is_opq && !op_valid) ? STAT_INS : E_stat;
            m_ctrl_d.icode = E_icode;
            m_ctrl_d.ifun  = E_ifun;
            m_ctrl_d.cnd   = e_cnd;
            m_ctrl_d.dst_e = e_dstE;
            m_ctrl_d.dst_m = E_dstM;
            m_val_a_d      = E_valA;
            m_val_e_d      = (is_opq && !op_valid) ? '0 : e_valE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q      <= CC_RESET;
            m_ctrl_q  <= M_CTRL_BUBBLE;
            m_val_a_q <= '0;
            m_val_e_q <= '0;
        end else begin
            cc_q      <= cc_d;
            m_ctrl_q  <= m_ctrl_d;
            m_val_a_q <= m_val_a_d;
            m_val_e_q <= m_val_e_d;
        end
    end

    assign cc_out  = cc_q;
    assign M_stat  = m_ctrl_q.stat;
    assign M_icode = m_ctrl_q.icode;
    assign M_ifun  = m_ctrl_q.ifun;
    assign M_cnd   = m_ctrl_q.cnd;
    assign M_dstE  = m_ctrl_q.dst_e;
    assign M_dstM  = m_ctrl_q.dst_m;
    assign M_valA  = m_val_a_q;
    assign M_valE  = m_val_e_q;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Scoreboard bench for y86_execute_stage; the mulq section is built only when
// Y86_EXEC_MUL_EN is defined.
module tb_y86_execute_stage;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic [1:0]      E_stat;
    logic [3:0]      E_icode, E_ifun, E_dstE, E_dstM;
    logic [XLEN-1:0] E_valA, E_valB, E_valC;
    logic            set_cc, M_stall, M_bubble;
    logic [1:0]      M_stat;
    logic [3:0]      M_icode, M_ifun, M_dstE, M_dstM;
    logic            M_cnd;
    logic [XLEN-1:0] M_valA, M_valE, e_valE;
    logic [3:0]      e_dstE;
    logic            e_cnd, e_busy;
    logic [2:0]      cc_out;

    y86_execute_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .set_cc(set_cc), .M_stall(M_stall), .M_bubble(M_bubble),
        .M_stat(M_stat), .M_icode(M_icode), .M_ifun(M_ifun), .M_cnd(M_cnd),
        .M_valA(M_valA), .M_valE(M_valE), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd), .e_busy(e_busy),
        .cc_out(cc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  stat;
        logic [3:0]  icode, ifun;
        logic        cnd;
        logic [63:0] val_a, val_e;
        logic [3:0]  dst_e, dst_m;
    } mreg_t;

    typedef struct {
        mreg_t       m;
        logic [2:0]  cc;
        logic [63:0] val_e;
        logic [3:0]  dst_e;
        logic        cnd;
        string       tag;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    mreg_t mdl_m;
    logic [2:0] mdl_cc;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic mreg_t bubble_m();
        mreg_t b;
        b.stat = 2'd0; b.icode = 4'h1; b.ifun = 4'h0; b.cnd = 1'b0;
        b.val_a = 64'd0; b.val_e = 64'd0; b.dst_e = 4'hF; b.dst_m = 4'hF;
        return b;
    endfunction

    // Monitor: compare current combinational and registered outputs against scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check({mon_e.tag, " e_valE"}, e_valE, mon_e.val_e);
            check({mon_e.tag, " e_dstE"}, 64'(e_dstE), 64'(mon_e.dst_e));
            check({mon_e.tag, " e_cnd"},  64'(e_cnd), 64'(mon_e.cnd));
            check({mon_e.tag, " e_busy"}, 64'(e_busy), 64'd0);
            check({mon_e.tag, " cc_out"}, 64'(cc_out), 64'(mon_e.cc));
            check({mon_e.tag, " M_stat"}, 64'(M_stat), 64'(mon_e.m.stat));
            check({mon_e.tag, " M_icode"}, 64'(M_icode), 64'(mon_e.m.icode));
            check({mon_e.tag, " M_ifun"}, 64'(M_ifun), 64'(mon_e.m.ifun));
            check({mon_e.tag, " M_cnd"},  64'(M_cnd), 64'(mon_e.m.cnd));
            check({mon_e.tag, " M_valA"}, M_valA, mon_e.m.val_a);
            check({mon_e.tag, " M_valE"}, M_valE, mon_e.m.val_e);
            check({mon_e.tag, " M_dstE"}, 64'(M_dstE), 64'(mon_e.m.dst_e));
            check({mon_e.tag, " M_dstM"}, 64'(M_dstM), 64'(mon_e.m.dst_m));
        end
    end

    task automatic drive_e(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                           input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                           input logic [3:0] de, input logic [3:0] dm, input logic sc,
                           input logic stl, input logic bub);
        E_stat = st; E_icode = ic; E_ifun = fn; E_valA = va; E_valB = vb; E_valC = vc;
        E_dstE = de; E_dstM = dm; set_cc = sc; M_stall = stl; M_bubble = bub;
    endtask

    // One cycle: drive E, predict from the ISA rules, push expectation, advance model.
    task automatic step(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                        input logic [3:0] de, input logic [3:0] dm, input logic sc,
                        input logic stl, input logic bub, input string tag);
        exp_t e;
        logic [64:0] w;
        logic [63:0] r;
        logic ok, bad, zf, sf, of, lt, cnd;
        mreg_t nm;
        drive_e(st, ic, fn, va, vb, vc, de, dm, sc, stl, bub);
        ok  = (ic == 4'h6) && (fn <= 4'd3);
        bad = (ic == 4'h6) && !ok;
        of  = 1'b0;
        case (ic)
            4'h2: r = va;
            4'h3: r = vc;
            4'h4, 4'h5: r = vb + vc;
            4'h6: begin
                case (fn)
                    4'd0: begin r = vb + va; w = {vb[63], vb} + {va[63], va}; of = w[64] ^ w[63]; end
                    4'd1: begin r = vb - va; w = {vb[63], vb} - {va[63], va}; of = w[64] ^ w[63]; end
                    4'd2: r = vb & va;
                    4'd3: r = vb ^ va;
                    default: r = 64'd0;
                endcase
            end
            4'h8, 4'hA: r = vb - 64'd8;
            4'h9, 4'hB: r = vb + 64'd8;
            default: r = 64'd0;
        endcase
        zf = (r == 64'd0);
        sf = r[63];
        lt = mdl_cc[1] ^ mdl_cc[0];
        cnd = 1'b0;
        if (ic == 4'h2 || ic == 4'h7) begin
            case (fn)
                4'd0: cnd = 1'b1;
                4'd1: cnd = lt | mdl_cc[2];
                4'd2: cnd = lt;
                4'd3: cnd = mdl_cc[2];
                4'd4: cnd = !mdl_cc[2];
                4'd5: cnd = !lt;
                4'd6: cnd = !lt && !mdl_cc[2];
                default: cnd = 1'b0;
            endcase
        end
        e.m = mdl_m; e.cc = mdl_cc; e.val_e = r; e.cnd = cnd; e.tag = tag;
        e.dst_e = (ic == 4'h2 && !cnd) ? 4'hF : de;
        exp_q.push_back(e);
        if (stl) nm = mdl_m;
        else if (bub) nm = bubble_m();
        else begin
            nm.stat = bad ? 2'd3 : st; nm.icode = ic; nm.ifun = fn; nm.cnd = cnd;
            nm.val_a = va; nm.val_e = bad ? 64'd0 : r; nm.dst_e = e.dst_e; nm.dst_m = dm;
        end
        @(posedge clk);
        #1;
        if (ok && sc && st == 2'd0) mdl_cc = {zf, sf, of};
        mdl_m = nm;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        drive_e(2'd0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mdl_m  = bubble_m();
        mdl_cc = 3'b100;
    endtask

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return {64{1'b1}};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        int busy_cnt;
        logic [3:0] ic, fn;
        rst_n = 1'b0;
        drive_e(2'd0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset M_stat", 64'(M_stat), 64'd0);
        check("reset M_icode", 64'(M_icode), 64'd1);
        check("reset M_dstE", 64'(M_dstE), 64'hF);
        check("reset M_dstM", 64'(M_dstM), 64'hF);
        check("reset M_valE", M_valE, 64'd0);
        check("reset cc_out", 64'(cc_out), 64'b100);
        check("reset e_busy", 64'(e_busy), 64'd0);
        reset_dut();

        step(2'd0, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0, "add_ovf");
        check("add_ovf M_valE", M_valE, 64'h8000_0000_0000_0000);
        check("add_ovf cc_out", 64'(cc_out), 64'b011);

        step(2'd0, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h1, 4'hF, 1'b1, 1'b0, 1'b0, "sub_eq");
        check("sub_eq cc_out", 64'(cc_out), 64'b100);
        step(2'd0, 4'h2, 4'h1, 64'h1234, 64'd0, 64'd0, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0, "cmovle_t");
        check("cmovle_t M_dstE", 64'(M_dstE), 64'h3);
        check("cmovle_t M_cnd", 64'(M_cnd), 64'd1);
        step(2'd0, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h1, 4'hF, 1'b1, 1'b0, 1'b0, "add_11");
        step(2'd0, 4'h2, 4'h1, 64'h1234, 64'd0, 64'd0, 4'h3, 4'hF, 1'b0, 1'b0, 1'b0, "cmovle_f");
        check("cmovle_f M_dstE", 64'(M_dstE), 64'hF);
        check("cmovle_f M_cnd", 64'(M_cnd), 64'd0);
        step(2'd0, 4'h6, 4'h1, 64'd9, 64'd9, 64'd0, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0, "nocc");
        check("nocc cc_out", 64'(cc_out), 64'b000);

        step(2'd0, 4'h6, 4'h3, 64'h0F, 64'hF0, 64'd0, 4'h5, 4'hF, 1'b1, 1'b0, 1'b0, "xor");
        step(2'd0, 4'h3, 4'h0, 64'd0, 64'd0, 64'd77, 4'h7, 4'hF, 1'b0, 1'b1, 1'b1, "stall1");
        step(2'd0, 4'h3, 4'h0, 64'd0, 64'd0, 64'd78, 4'h7, 4'hF, 1'b0, 1'b1, 1'b1, "stall2");
        check("stall M_valE", M_valE, 64'hFF);
        check("stall M_icode", 64'(M_icode), 64'h6);
        step(2'd0, 4'h3, 4'h0, 64'd0, 64'd0, 64'd79, 4'h7, 4'hF, 1'b0, 1'b0, 1'b1, "bubble");
        check("bubble M_icode", 64'(M_icode), 64'h1);
        check("bubble M_dstE", 64'(M_dstE), 64'hF);
`ifndef Y86_EXEC_MUL_EN
        step(2'd0, 4'h6, 4'h4, 64'd3, 64'd7, 64'd0, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0, "ifun4");
        check("ifun4 M_stat", 64'(M_stat), 64'd3);
        check("ifun4 M_valE", M_valE, 64'd0);
`endif
        step(2'd0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, "nop");

        for (int i = 0; i < 400; i++) begin
            ic = 4'($urandom_range(0, 15));
            if (ic > 4'hB && $urandom_range(0, 3) != 0) ic = 4'h6;
            fn = (ic == 4'h6) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 8));
`ifdef Y86_EXEC_MUL_EN
            if (ic == 4'h6 && fn == 4'h4) fn = 4'h5;
`endif
            step(($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0, ic, fn,
                 rnd_val(), rnd_val(), rnd_val(), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), "rand");
        end

`ifdef Y86_EXEC_MUL_EN
        reset_dut();
        drive_e(2'd0, 4'h6, 4'h4, 64'd7, 64'd3, 64'd0, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!e_busy) break;
            busy_cnt++;
        end
        check("mul busy cycles", 64'(busy_cnt), 64'(XLEN + 1));
        check("mul done e_valE", e_valE, 64'd21);
        @(posedge clk);
        #1;
        check("mul M_valE", M_valE, 64'd21);
        check("mul M_icode", 64'(M_icode), 64'h6);
        check("mul cc_out", 64'(cc_out), 64'b000);
        drive_e(2'd0, 4'h6, 4'h4, 64'd5, 64'd0, 64'd0, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("squash busy before", 64'(e_busy), 64'd1);
        @(posedge clk);
        #1;
        drive_e(2'd0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("squash busy", 64'(e_busy), 64'd0);
        @(negedge clk);
        check("squash busy next", 64'(e_busy), 64'd0);
        check("squash cc_out", 64'(cc_out), 64'b000);
        drive_e(2'd0, 4'h6, 4'h4, 64'd7, 64'd3, 64'd0, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst midrun M_icode", 64'(M_icode), 64'h1);
        check("rst midrun M_dstE", 64'(M_dstE), 64'hF);
        check("rst midrun cc_out", 64'(cc_out), 64'b100);
        drive_e(2'd0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst midrun e_busy", 64'(e_busy), 64'd0);
        reset_dut();
        step(2'd0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, "post_mul");
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
